ultraram_burst_reader: RTL and testbench

Sequential read-burst engine that drives the read side of one port of the 64-bit ultraRAM true-dual-port memory. It streams the returned words downstream over a valid/ready interface. The block owns the port's rden/rdaddrs pair and absorbs the RAM's one-cycle read latency with a 4-entry output FIFO, so downstream backpressure never loses data. It is used to stream stored vectors or weights out of ultraRAM into the compute pipeline.

---
 rtl/ultraram_burst_reader_if.sv | 35 +++
 rtl/ultraram_burst_reader.sv | 161 ++++++++++++++++
 tb/tb_ultraram_burst_reader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ultraram_burst_reader_if.sv
// Bundle of the burst reader's control, RAM read-port and output-stream signals.
// Stream handshake: a word moves when out_valid & out_ready are both high on a rising
// edge; once raised, out_valid stays high with out_data/out_last stable until that
// transfer, except when abort or reset flushes the buffer.
interface ultraram_burst_reader_if #(
  parameter int ADDRS_WIDTH = 12,
  parameter int DWIDTH      = 64,
  parameter int LEN_WIDTH   = 13
);
  logic                   start;
  logic [ADDRS_WIDTH-1:0] base_addrs;
  logic [LEN_WIDTH-1:0]   burst_len;
  logic                   abort;
  logic                   port_busy;
  logic                   rden;
  logic [ADDRS_WIDTH-1:0] rdaddrs;
  logic [DWIDTH-1:0]      rddata;
  logic                   out_valid;
  logic [DWIDTH-1:0]      out_data;
  logic                   out_last;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic [1:0]             state_dbg;

  modport slave (
    input  start, base_addrs, burst_len, abort, port_busy, rddata, out_ready,
    output rden, rdaddrs, out_valid, out_data, out_last, busy, done, state_dbg
  );

  modport master (
    output start, base_addrs, burst_len, abort, port_busy, rddata, out_ready,
    input  rden, rdaddrs, out_valid, out_data, out_last, busy, done, state_dbg
  );
endinterface

// File: rtl/ultraram_burst_reader.sv
// Streams a burst of consecutive ultraRAM words out over valid/ready, absorbing the
// RAM's one-cycle read latency in a 4-entry FIFO sized by the read-credit rule.
module ultraram_burst_reader #(
  parameter int ADDRS_WIDTH = 12,
  parameter int DWIDTH      = 64,
  parameter int LEN_WIDTH   = 13
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  ultraram_burst_reader_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEPTH = 4;

  state_t                 state_q, state_d;
  logic [ADDRS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRS_WIDTH-1:0] rdaddrs_q, rdaddrs_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   sent_q, sent_d;
  logic                   rd_pending_q, rd_pending_d;
  logic                   done_q, done_d;
  logic [DWIDTH-1:0]      data_mem_q [DEPTH];
  logic [DWIDTH-1:0]      data_mem_d [DEPTH];
  logic [DEPTH-1:0]       last_mem_q, last_mem_d;
  logic [1:0]             wr_ptr_q, wr_ptr_d;
  logic [1:0]             rd_ptr_q, rd_ptr_d;
  logic [2:0]             count_q, count_d;

  logic rden;
  logic credit;
  logic push;
  logic pop;
  logic out_valid;
  logic head_last;
  logic last_push;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    len_d        = len_q;
    sent_d       = sent_q;
    done_d       = 1'b0;
    data_mem_d   = data_mem_q;
    last_mem_d   = last_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    out_valid = (count_q != 3'd0);
    head_last = last_mem_q[rd_ptr_q];
    pop       = out_valid & bus.out_ready;
    push      = rd_pending_q;
    // Words already buffered plus the one in flight must leave room for another read.
    credit    = ({1'b0, count_q} + {3'b000, rd_pending_q}) < 4'd4;
    rden      = (state_q == RUN) && (remaining_q != '0) && !bus.port_busy && credit;
    rdaddrs_d = rden ? addr_q : rdaddrs_q;
    rd_pending_d = rden;
    last_push = (sent_q == len_q - LEN_WIDTH'(1));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.burst_len != '0) begin
            addr_d      = bus.base_addrs;
            remaining_d = bus.burst_len;
            len_d       = bus.burst_len;
            sent_d      = '0;
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (rden) begin
          addr_d      = addr_q + ADDRS_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      data_mem_d[wr_ptr_q] = bus.rddata;
      last_mem_d[wr_ptr_q] = last_push;
      wr_ptr_d             = wr_ptr_q + 2'd1;
      sent_d               = sent_q + LEN_WIDTH'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // Abort drops buffered data and the word still coming back from the RAM.
    if (bus.abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      count_d      = 3'd0;
      wr_ptr_d     = 2'd0;
      rd_ptr_d     = 2'd0;
      rd_pending_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rdaddrs_q    <= '0;
      remaining_q  <= '0;
      len_q        <= '0;
      sent_q       <= '0;
      rd_pending_q <= 1'b0;
      done_q       <= 1'b0;
      last_mem_q   <= '0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rdaddrs_q    <= rdaddrs_d;
      remaining_q  <= remaining_d;
      len_q        <= len_d;
      sent_q       <= sent_d;
      rd_pending_q <= rd_pending_d;
      done_q       <= done_d;
      data_mem_q   <= data_mem_d;
      last_mem_q   <= last_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign bus.rden      = rden;
  assign bus.rdaddrs   = rdaddrs_d;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign bus.out_last  = out_valid & head_last;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_ultraram_burst_reader.sv
// Directed bench for ultraram_burst_reader with a behavioural one-cycle-latency RAM.
module tb_ultraram_burst_reader;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ultraram_burst_reader_if #(.ADDRS_WIDTH(12), .DWIDTH(64), .LEN_WIDTH(13)) bus ();

  ultraram_burst_reader #(.ADDRS_WIDTH(12), .DWIDTH(64), .LEN_WIDTH(13)) dut (
    .CLK    (clk),
    .RESETn (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ram_word(input logic [11:0] a);
    return {20'hABCDE, 20'h00000, ~a, a};
  endfunction

  always @(posedge clk) begin
    if (bus.rden) bus.rddata <= ram_word(bus.rdaddrs);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs are already set at this negedge; check outputs, then advance.
  task automatic cyc(input string tag, input logic e_rden, input logic [11:0] e_addr,
                     input logic e_valid, input logic [11:0] e_daddr, input logic e_last,
                     input logic e_busy, input logic e_done);
    #1;
    chk({tag, ".rden"}, bus.rden, e_rden);
    if (e_rden) chk({tag, ".rdaddrs"}, bus.rdaddrs, e_addr);
    chk({tag, ".valid"}, bus.out_valid, e_valid);
    if (e_valid) begin
      chk({tag, ".data"}, bus.out_data, ram_word(e_daddr));
      chk({tag, ".last"}, bus.out_last, e_last);
    end
    chk({tag, ".busy"}, bus.busy, e_busy);
    chk({tag, ".done"}, bus.done, e_done);
    @(negedge clk);
  endtask

  task automatic start_burst(input logic [11:0] base, input logic [12:0] len);
    bus.start      = 1'b1;
    bus.base_addrs = base;
    bus.burst_len  = len;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.base_addrs = '0;
    bus.burst_len  = '0;
    bus.abort      = 1'b0;
    bus.port_busy  = 1'b0;
    bus.out_ready  = 1'b1;
    bus.rddata     = '0;

    repeat (3) @(negedge clk);
    chk("rst.rden", bus.rden, 1'b0);
    chk("rst.rdaddrs", bus.rdaddrs, 12'h000);
    chk("rst.valid", bus.out_valid, 1'b0);
    chk("rst.data", bus.out_data, 64'h0);
    chk("rst.last", bus.out_last, 1'b0);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.done", bus.done, 1'b0);
    chk("rst.state", bus.state_dbg, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst
    start_burst(12'h010, 13'd4);
    cyc("basic_t0", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    bus.start = 1'b0;
    cyc("basic_t1", 1, 12'h010, 0, 12'h000, 0, 1, 0);
    cyc("basic_t2", 1, 12'h011, 0, 12'h000, 0, 1, 0);
    cyc("basic_t3", 1, 12'h012, 1, 12'h010, 0, 1, 0);
    cyc("basic_t4", 1, 12'h013, 1, 12'h011, 0, 1, 0);
    cyc("basic_t5", 0, 12'h000, 1, 12'h012, 0, 1, 0);
    cyc("basic_t6", 0, 12'h000, 1, 12'h013, 1, 1, 0);
    cyc("basic_t7", 0, 12'h000, 0, 12'h000, 0, 0, 1);
    cyc("basic_t8", 0, 12'h000, 0, 12'h000, 0, 0, 0);

    // Address wrap-around
    start_burst(12'hFFE, 13'd4);
    cyc("wrap_t0", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    bus.start = 1'b0;
    cyc("wrap_t1", 1, 12'hFFE, 0, 12'h000, 0, 1, 0);
    cyc("wrap_t2", 1, 12'hFFF, 0, 12'h000, 0, 1, 0);
    cyc("wrap_t3", 1, 12'h000, 1, 12'hFFE, 0, 1, 0);
    cyc("wrap_t4", 1, 12'h001, 1, 12'hFFF, 0, 1, 0);
    cyc("wrap_t5", 0, 12'h000, 1, 12'h000, 0, 1, 0);
    cyc("wrap_t6", 0, 12'h000, 1, 12'h001, 1, 1, 0);
    cyc("wrap_t7", 0, 12'h000, 0, 12'h000, 0, 0, 1);

    // Backpressure: out_ready low for cycles t+3..t+12
    start_burst(12'h200, 13'd8);
    cyc("bp_t0", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    bus.start = 1'b0;
    cyc("bp_t1", 1, 12'h200, 0, 12'h000, 0, 1, 0);
    cyc("bp_t2", 1, 12'h201, 0, 12'h000, 0, 1, 0);
    bus.out_ready = 1'b0;
    cyc("bp_t3", 1, 12'h202, 1, 12'h200, 0, 1, 0);
    cyc("bp_t4", 1, 12'h203, 1, 12'h200, 0, 1, 0);
    for (int i = 5; i <= 12; i++) cyc($sformatf("bp_t%0d", i), 0, 12'h000, 1, 12'h200, 0, 1, 0);
    bus.out_ready = 1'b1;
    cyc("bp_t13", 0, 12'h000, 1, 12'h200, 0, 1, 0);
    cyc("bp_t14", 1, 12'h204, 1, 12'h201, 0, 1, 0);
    cyc("bp_t15", 1, 12'h205, 1, 12'h202, 0, 1, 0);
    cyc("bp_t16", 1, 12'h206, 1, 12'h203, 0, 1, 0);
    cyc("bp_t17", 1, 12'h207, 1, 12'h204, 0, 1, 0);
    cyc("bp_t18", 0, 12'h000, 1, 12'h205, 0, 1, 0);
    cyc("bp_t19", 0, 12'h000, 1, 12'h206, 0, 1, 0);
    cyc("bp_t20", 0, 12'h000, 1, 12'h207, 1, 1, 0);
    cyc("bp_t21", 0, 12'h000, 0, 12'h000, 0, 0, 1);

    // Port conflict in the cycle after start
    start_burst(12'h300, 13'd3);
    cyc("pb_t0", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    bus.start     = 1'b0;
    bus.port_busy = 1'b1;
    cyc("pb_t1", 0, 12'h000, 0, 12'h000, 0, 1, 0);
    bus.port_busy = 1'b0;
    cyc("pb_t2", 1, 12'h300, 0, 12'h000, 0, 1, 0);
    cyc("pb_t3", 1, 12'h301, 0, 12'h000, 0, 1, 0);
    cyc("pb_t4", 1, 12'h302, 1, 12'h300, 0, 1, 0);
    cyc("pb_t5", 0, 12'h000, 1, 12'h301, 0, 1, 0);
    cyc("pb_t6", 0, 12'h000, 1, 12'h302, 1, 1, 0);
    cyc("pb_t7", 0, 12'h000, 0, 12'h000, 0, 0, 1);
    cyc("pb_t8", 0, 12'h000, 0, 12'h000, 0, 0, 0);

    // Abort on the cycle the second word is presented
    start_burst(12'h400, 13'd4);
    cyc("ab_t0", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    bus.start = 1'b0;
    cyc("ab_t1", 1, 12'h400, 0, 12'h000, 0, 1, 0);
    cyc("ab_t2", 1, 12'h401, 0, 12'h000, 0, 1, 0);
    cyc("ab_t3", 1, 12'h402, 1, 12'h400, 0, 1, 0);
    bus.abort = 1'b1;
    cyc("ab_t4", 1, 12'h403, 1, 12'h401, 0, 1, 0);
    bus.abort = 1'b0;
    #1 chk("ab_t5.state", bus.state_dbg, 2'd0);
    @(negedge clk);
    cyc("ab_t6", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    cyc("ab_t7", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    start_burst(12'h500, 13'd1);
    cyc("ab2_t0", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    bus.start = 1'b0;
    cyc("ab2_t1", 1, 12'h500, 0, 12'h000, 0, 1, 0);
    cyc("ab2_t2", 0, 12'h000, 0, 12'h000, 0, 1, 0);
    cyc("ab2_t3", 0, 12'h000, 1, 12'h500, 1, 1, 0);
    cyc("ab2_t4", 0, 12'h000, 0, 12'h000, 0, 0, 1);

    // Zero-length request
    start_burst(12'h123, 13'd0);
    cyc("zl_t0", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    bus.start = 1'b0;
    cyc("zl_t1", 0, 12'h000, 0, 12'h000, 0, 0, 1);
    cyc("zl_t2", 0, 12'h000, 0, 12'h000, 0, 0, 0);

    // Reset in the middle of a burst
    start_burst(12'h600, 13'd4);
    cyc("mr_t0", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    bus.start = 1'b0;
    cyc("mr_t1", 1, 12'h600, 0, 12'h000, 0, 1, 0);
    cyc("mr_t2", 1, 12'h601, 0, 12'h000, 0, 1, 0);
    rst_n = 1'b0;
    cyc("mr_t3", 1, 12'h602, 1, 12'h600, 0, 1, 0);
    rst_n = 1'b1;
    #1;
    chk("mr_t4.rden", bus.rden, 1'b0);
    chk("mr_t4.rdaddrs", bus.rdaddrs, 12'h000);
    chk("mr_t4.valid", bus.out_valid, 1'b0);
    chk("mr_t4.data", bus.out_data, 64'h0);
    chk("mr_t4.last", bus.out_last, 1'b0);
    chk("mr_t4.busy", bus.busy, 1'b0);
    chk("mr_t4.done", bus.done, 1'b0);
    @(negedge clk);
    cyc("mr_t5", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    start_burst(12'h100, 13'd2);
    cyc("pr_t0", 0, 12'h000, 0, 12'h000, 0, 0, 0);
    bus.start = 1'b0;
    cyc("pr_t1", 1, 12'h100, 0, 12'h000, 0, 1, 0);
    cyc("pr_t2", 1, 12'h101, 0, 12'h000, 0, 1, 0);
    cyc("pr_t3", 0, 12'h000, 1, 12'h100, 0, 1, 0);
    cyc("pr_t4", 0, 12'h000, 1, 12'h101, 1, 1, 0);
    cyc("pr_t5", 0, 12'h000, 0, 12'h000, 0, 0, 1);
    cyc("pr_t6", 0, 12'h000, 0, 12'h000, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
